// File: rtl/looper_brch_pkg.sv
// Shared types for the branch checkpoint controller.
//   IDX_W / POS_W : default ROB-index and freelist-position widths
//   ckpt_entry_t  : one checkpoint slot {ROB index, freelist position}
//   state_t       : controller state (RUN, FLUSH)
package looper_brch_pkg;

    localparam int IDX_W = 6;
    localparam int POS_W = 7;   // includes the freelist wrap bit

    typedef struct packed {
        logic [IDX_W-1:0] indx;
        logic [POS_W-1:0] pos;
    } ckpt_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/brch_lane_compact.sv
// Prefix popcount over the per-lane branch flags of one decode bundle.
// Ports:
//   lane_vld  in   LANES            qualified branch flags, lane 0 oldest
//   lane_off  out  LANES x OFF_W    slot offset from tail for each lane
//                                   (only meaningful where lane_vld is set)
//   need      out  OFF_W            total number of slots the bundle needs
module brch_lane_compact #(
    parameter int LANES = 4,
    parameter int OFF_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]            lane_vld,
    output logic [LANES-1:0][OFF_W-1:0] lane_off,
    output logic [OFF_W-1:0]            need
);

    logic [OFF_W-1:0] acc;

    // Exclusive prefix sum: each branch lane lands at the count of older branches.
    always_comb begin
        acc      = '0;
        lane_off = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_off[i] = acc;
            acc         = acc + OFF_W'(lane_vld[i]);
        end
        need = acc;
    end

endmodule

// File: rtl/brch_ckpt_ctrl.sv
// Branch checkpoint FIFO controller for the allocation stage.
// Records up to LANES branches per bundle as {ROB index, freelist position},
// retires the head on branch commit, and on a mispredict drops the branch and
// every younger checkpoint, then pulses the freelist recovery pointer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bndl_vld, brch_vld       bundle present, per-lane branch flags (lane 0 oldest)
//   brch_indx, brch_pos      per-lane ROB index / freelist position (packed by lane)
//   ckpt_stall               bundle cannot be accepted this cycle
//   cmt_brch, cmt_brch_indx  head branch commits, with its ROB index
//   mis_pred, brch_mis_indx  mispredict, with the branch's ROB index
//   rcvr_vld, rcvr_pos       one-cycle freelist recovery pulse and pointer
//   brch_cnt                 checkpoints currently held
//   ckpt_err                 protocol error pulse (bad commit / unknown or late mispredict)
// Optional: define BRCH_CKPT_STATS_EN to add saturating counters
//   stall_cyc_cnt (cycles a bundle waited on stall) and mis_cnt (mispredict hits).
module brch_ckpt_ctrl #(
    parameter int DEPTH = 4,
    parameter int LANES = 4,
    parameter int IDX_W = looper_brch_pkg::IDX_W,
    parameter int POS_W = looper_brch_pkg::POS_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bndl_vld,
    input  logic [LANES-1:0]           brch_vld,
    input  logic [LANES*IDX_W-1:0]     brch_indx,
    input  logic [LANES*POS_W-1:0]     brch_pos,
    output logic                       ckpt_stall,
    input  logic                       cmt_brch,
    input  logic [IDX_W-1:0]           cmt_brch_indx,
    input  logic                       mis_pred,
    input  logic [IDX_W-1:0]           brch_mis_indx,
    output logic                       rcvr_vld,
    output logic [POS_W-1:0]           rcvr_pos,
    output logic [$clog2(DEPTH+1)-1:0] brch_cnt,
    output logic                       ckpt_err
`ifdef BRCH_CKPT_STATS_EN
    ,
    output logic [15:0]                stall_cyc_cnt,
    output logic [15:0]                mis_cnt
`endif
);

    import looper_brch_pkg::*;

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int OFF_W = $clog2(LANES + 1);

    ckpt_entry_t                mem [DEPTH];
    logic [PTR_W-1:0]           head, tail, ptr_diff;
    state_t                     state, state_nxt;
    logic [POS_W-1:0]           pend_pos_p1;
    logic                       ckpt_err_p1;

    logic [LANES-1:0]           lane_vld;
    logic [LANES-1:0][OFF_W-1:0] lane_off;
    logic [OFF_W-1:0]           need;
    logic [AW-1:0]              wr_slot [LANES];

    logic [AW-1:0]              slot_rel [DEPTH];
    logic [DEPTH-1:0]           slot_hit;
    logic [AW-1:0]              mis_off;
    logic [POS_W-1:0]           mis_pos;

    logic empty, push, cmt_ok, mis_hit, cmt_err, mis_err;

    assign lane_vld = brch_vld & {LANES{bndl_vld}};

    brch_lane_compact #(.LANES(LANES), .OFF_W(OFF_W)) u_compact (
        .lane_vld (lane_vld),
        .lane_off (lane_off),
        .need     (need)
    );

    assign ptr_diff = tail - head;
    assign brch_cnt = ptr_diff;
    assign empty    = (head == tail);

    // Free-slot check uses the registered count; a same-cycle commit is not credited.
    assign ckpt_stall = (state == FLUSH) | mis_pred | (int'(need) > DEPTH - int'(brch_cnt));
    assign push       = bndl_vld & ~ckpt_stall;

    assign cmt_ok  = cmt_brch && !empty && (mem[head[AW-1:0]].indx == cmt_brch_indx);
    assign cmt_err = cmt_brch && !cmt_ok;

    // A slot is live when its distance from head is below the occupancy.
    for (genvar j = 0; j < DEPTH; j++) begin : g_slot
        assign slot_rel[j] = AW'(j) - head[AW-1:0];
        assign slot_hit[j] = ({1'b0, slot_rel[j]} < ptr_diff) &&
                             (mem[j].indx == brch_mis_indx);
    end

    // ROB indices are unique, so at most one slot can hit.
    always_comb begin
        mis_off = '0;
        mis_pos = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (slot_hit[j]) begin
                mis_off = slot_rel[j];
                mis_pos = mem[j].pos;
            end
        end
    end

    assign mis_hit = mis_pred && (state == RUN) && (|slot_hit);
    assign mis_err = mis_pred && !mis_hit;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign wr_slot[i] = tail[AW-1:0] + AW'(lane_off[i]);
    end

    // Control: pointers and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            ckpt_err_p1 <= 1'b0;
        end else begin
            ckpt_err_p1 <= cmt_err | mis_err;
            if (mis_hit) begin
                // Truncate at the mispredicted branch. A commit of that same
                // branch is dropped with it; otherwise the commit still retires.
                tail <= head + PTR_W'(mis_off);
                if (cmt_ok && (mis_off != '0))
                    head <= head + 1'b1;
            end else begin
                if (cmt_ok)
                    head <= head + 1'b1;
                if (push)
                    tail <= tail + PTR_W'(need);
            end
        end
    end

    // Data: checkpoint storage and latched recovery position.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_vld[i]) begin
                    mem[wr_slot[i]] <= '{indx: brch_indx[i*IDX_W +: IDX_W],
                                         pos:  brch_pos[i*POS_W +: POS_W]};
                end
            end
        end
        if (mis_hit)
            pend_pos_p1 <= mis_pos;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // FSM next state: FLUSH always lasts a single cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mis_hit) state_nxt = FLUSH;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        rcvr_vld = (state == FLUSH);
        rcvr_pos = rcvr_vld ? pend_pos_p1 : '0;
    end

    assign ckpt_err = ckpt_err_p1;

`ifdef BRCH_CKPT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cyc_cnt <= '0;
            mis_cnt       <= '0;
        end else begin
            if (bndl_vld && ckpt_stall && (stall_cyc_cnt != 16'hFFFF))
                stall_cyc_cnt <= stall_cyc_cnt + 16'd1;
            if (mis_hit && (mis_cnt != 16'hFFFF))
                mis_cnt <= mis_cnt + 16'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/brch_ckpt_ctrl.md
Name: brch_ckpt_ctrl

Overview:
- Controller for the branch checkpoint FIFO in the allocation stage.
- Accepts up to 4 branches per decode bundle and records each as {ROB index, freelist alloc position}.
- Stalls allocation when checkpoint slots run out, retires the head checkpoint on branch commit, and flushes the mispredicted branch plus all younger checkpoints.
- On mispredict, drives the freelist recovery pointer.

Parameters:
- DEPTH, 4, number of checkpoint slots (power of 2).
- LANES, 4, decode lanes per bundle.
- IDX_W, 6, ROB index width.
- POS_W, 7, freelist position width, including the wrap bit.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- bndl_vld  in  1  allocation stage presents a bundle this cycle.
- brch_vld  in  LANES  per-lane "is branch" flags; lane 0 is oldest.
- brch_indx  in  LANES*IDX_W  per-lane ROB index; lane i at [i*IDX_W +: IDX_W].
- brch_pos  in  LANES*POS_W  per-lane freelist alloc pointer after that lane allocates.
- ckpt_stall  out  1  bundle cannot be accepted.
- cmt_brch  in  1  oldest outstanding branch commits.
- cmt_brch_indx  in  IDX_W  ROB index of the committing branch.
- mis_pred  in  1  branch mispredicted.
- brch_mis_indx  in  IDX_W  ROB index of the mispredicted branch.
- rcvr_vld  out  1  recovery pointer valid (one-cycle pulse).
- rcvr_pos  out  POS_W  freelist pointer to restore.
- brch_cnt  out  $clog2(DEPTH+1)  checkpoints currently held.
- ckpt_err  out  1  protocol error pulse.

Behaviour:
- Storage: DEPTH entries of {indx, pos}; head/tail pointers are log2(DEPTH)+1 bits (extra wrap bit). Full when pointers are equal except the MSB; empty when fully equal.
- Reset: head=tail=0, state=RUN. All outputs 0, except ckpt_stall=0 and brch_cnt=0. Reset during FLUSH aborts it, and rcvr_vld stays 0.
- need = popcount(brch_vld & {LANES{bndl_vld}}).
- ckpt_stall (combinational) = (state==FLUSH) | mis_pred | (need > DEPTH - brch_cnt).
- Free-slot count ignores a same-cycle commit; this is conservative and intended.
- Push: when bndl_vld & !ckpt_stall, valid lanes are written in lane order to tail, tail+1, …, and tail advances by need. Lanes with brch_vld=0 consume no slot.
- Commit: cmt_brch with a non-empty FIFO and cmt_brch_indx == entry[head].indx advances head by 1.
  - Commit on an empty FIFO or with an index mismatch: no pointer change, ckpt_err=1 next cycle.
- Mispredict: compare brch_mis_indx against all valid entries (head..tail-1). Indices are unique, so equality compare suffices.
  - Hit at slot k: tail<=k (drops the branch and everything younger), pending pos latched from entry[k].pos, state RUN→FLUSH.
  - Miss: no change, ckpt_err=1 next cycle, state stays RUN.
- FSM: RUN → FLUSH on a mispredict hit.
  - FLUSH lasts exactly 1 cycle: rcvr_vld=1, rcvr_pos=latched pos, stall held, then → RUN.
  - A mis_pred arriving in FLUSH is ignored and raises ckpt_err.
- Same-cycle events:
  - Mispredict beats push (push blocked via stall).
  - Commit and mispredict-hit both apply. If the hit slot is head, the commit is also dropped: head stays, tail<=head, FIFO empty, no ckpt_err.
  - Commit and push apply together.
- Latency: push/commit effects are visible in brch_cnt the next cycle; rcvr_pos is valid 1 cycle after mis_pred.
- Pointer arithmetic wraps modulo 2*DEPTH.
- brch_cnt = tail - head (registered-pointer difference).

Optional Feature:
- Macro: BRCH_CKPT_STATS_EN.
- When defined, adds outputs stall_cyc_cnt[15:0] and mis_cnt[15:0]. Both are saturating counters, cleared by rst.
  - stall_cyc_cnt increments on each cycle with bndl_vld & ckpt_stall.
  - mis_cnt increments on each mispredict hit.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Package looper_brch_pkg holds:
  - IDX_W and POS_W constants.
  - the ckpt_entry_t struct {indx, pos}.
  - the state enum {RUN, FLUSH}.
- One sub-module, brch_lane_compact: combinational prefix popcount that maps each valid lane to a slot offset and produces need. The controller instantiates it once.

Test Plan:
- Reset, then bndl_vld=1, brch_vld=4'b0101, indx {9,4}, pos {0x12,0x10} → slots 0/1 = {4,0x10},{9,0x12}; brch_cnt=2; stall=0.
- With 3 held, present brch_vld=4'b0011 → ckpt_stall=1, no write. Next cycle cmt_brch of head → brch_cnt=2. Re-present the bundle → accepted, brch_cnt=4 (full).
- Hold branches {4,9,13}, mis_pred indx 9 → next cycle rcvr_vld=1, rcvr_pos=stored pos of 9, brch_cnt=1, stall high during FLUSH.
- Same cycle: cmt_brch of head indx 4 and mis_pred indx 4 → FIFO empty, rcvr_pos=pos of 4, ckpt_err=0.
- Commit indx 7 when head holds 4, then mis_pred indx 33 (absent) → ckpt_err pulses each time, pointers unchanged.
- Push/commit 10 branches cycling through all slots → correct FIFO order across the wrap, full/empty flags correct at head==tail with both MSB cases. Assert rst mid-FLUSH → rcvr_vld=0, brch_cnt=0.
